imem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port, synchronous instruction memory. Shares the memory between the core's fetch port (read-only) and the program loader/debug port (read/write). Converts byte addresses to word indices, rejects misaligned and out-of-range accesses, and returns each read one cycle after its grant. Sits between the fetch stage, the loader, and the instruction memory array.

---
 rtl/imem_arbiter_if.sv | 41 ++++
 rtl/imem_arbiter.sv | 105 ++++++++++
 tb/tb_imem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory signal bundle for imem_arbiter
interface imem_arbiter_if #(
  parameter int IDX_W = 8
);
  logic             f_req;
  logic [31:0]      f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [31:0]      f_rdata;
  logic             f_err;

  logic             l_req;
  logic             l_we;
  logic [31:0]      l_addr;
  logic [31:0]      l_wdata;
  logic             l_lock;
  logic             l_gnt;
  logic             l_rvalid;
  logic [31:0]      l_rdata;
  logic             l_err;

  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_idx, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/loader arbiter and sequencer for the instruction memory
module imem_arbiter #(
  parameter int DEPTH        = 256,
  parameter int IDX_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]       starve_cnt;
  logic             pend_valid;
  logic             pend_port;
  logic             pend_err;
  logic             pend_write;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  logic             f_bad;
  logic             l_bad;
  logic             l_force;
  logic             f_gnt;
  logic             l_gnt;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      wdata_c;

  // DEPTH is a power of two, so the range check reduces to the bits above the index
  assign f_bad   = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr[31:IDX_W+2] != '0);
  assign l_bad   = (bus.l_addr[1:0] != 2'b00) || (bus.l_addr[31:IDX_W+2] != '0);
  assign l_force = bus.l_req && (starve_cnt >= LIMIT);

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (bus.l_lock) begin
        l_gnt = bus.l_req;
      end else if (l_force) begin
        l_gnt = 1'b1;
      end else if (bus.f_req) begin
        f_gnt = 1'b1;
      end else if (bus.l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  // index and write data hold their previous value while the memory is idle
  always_comb begin
    idx_c   = idx_q;
    wdata_c = wdata_q;
    if (l_gnt) begin
      idx_c   = bus.l_addr[IDX_W+1:2];
      wdata_c = bus.l_wdata;
    end else if (f_gnt) begin
      idx_c   = bus.f_addr[IDX_W+1:2];
    end
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.mem_en    = (f_gnt && !f_bad) || (l_gnt && !l_bad);
  assign bus.mem_we    = l_gnt && bus.l_we && !l_bad;
  assign bus.mem_idx   = idx_c;
  assign bus.mem_wdata = wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      if (!bus.l_req || l_gnt) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      idx_q   <= idx_c;
      wdata_q <= wdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      pend_err   <= 1'b0;
      pend_write <= 1'b0;
    end else begin
      pend_valid <= f_gnt || l_gnt;
      pend_port  <= l_gnt;
      pend_err   <= l_gnt ? l_bad : f_bad;
      pend_write <= l_gnt && bus.l_we;
    end
  end

  assign bus.f_rvalid = pend_valid && !pend_port;
  assign bus.f_err    = pend_valid && !pend_port && pend_err;
  assign bus.f_rdata  = (pend_valid && !pend_port && !pend_err) ? bus.mem_rdata : 32'd0;
  assign bus.l_rvalid = pend_valid && pend_port;
  assign bus.l_err    = pend_valid && pend_port && pend_err;
  assign bus.l_rdata  = (pend_valid && pend_port && !pend_err && !pend_write) ? bus.mem_rdata : 32'd0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - table-driven bench for imem_arbiter with a behavioural memory
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_arbiter_if #(.IDX_W(8)) bus ();

  imem_arbiter #(.DEPTH(256), .IDX_W(8), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // memory preloads with 0x1000_0000 + index (word 3 holds an instruction) during reset
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k);
      mem[3] <= 32'h0020_81B3;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_idx] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_idx];
    end
  end

  typedef struct {
    logic [31:0] f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock;
    logic [31:0] f_gnt, l_gnt, mem_en, mem_we, idx, starve;
    logic [31:0] f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata;
  } vec_t;

  localparam int NV = 24;
  vec_t v [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //        fr fa      lr lw la     lwdata        lk  fg lg me mw idx st  frv fe frdata         lrv le lrdata
    v[0]  = '{0, 0,      0, 0, 0,     0,            0,  0, 0, 0, 0, 0,  0,  0, 0, 0,             0, 0, 0};
    v[1]  = '{1, 'h0C,   0, 0, 0,     0,            0,  1, 0, 1, 0, 3,  0,  0, 0, 0,             0, 0, 0};
    v[2]  = '{0, 0,      1, 1, 'h10,  'h00A0_0093,  0,  0, 1, 1, 1, 4,  0,  1, 0, 'h0020_81B3,   0, 0, 0};
    v[3]  = '{1, 'h10,   0, 0, 0,     0,            0,  1, 0, 1, 0, 4,  0,  0, 0, 0,             1, 0, 0};
    v[4]  = '{1, 'h06,   0, 0, 0,     0,            0,  1, 0, 0, 0, 0,  0,  1, 0, 'h00A0_0093,   0, 0, 0};
    v[5]  = '{0, 0,      1, 1, 'h400, 'hDEAD_BEEF,  0,  0, 1, 0, 0, 0,  0,  1, 1, 0,             0, 0, 0};
    v[6]  = '{0, 0,      1, 0, 'h0,   0,            0,  0, 1, 1, 0, 0,  0,  0, 0, 0,             1, 1, 0};
    v[7]  = '{0, 0,      0, 0, 0,     0,            0,  0, 0, 0, 0, 0,  0,  0, 0, 0,             1, 0, 'h1000_0000};
    v[8]  = '{1, 'h08,   1, 0, 'h14,  0,            0,  1, 0, 1, 0, 2,  0,  0, 0, 0,             0, 0, 0};
    v[9]  = '{1, 'h08,   1, 0, 'h14,  0,            0,  1, 0, 1, 0, 2,  1,  1, 0, 'h1000_0002,   0, 0, 0};
    v[10] = '{1, 'h08,   1, 0, 'h14,  0,            0,  1, 0, 1, 0, 2,  2,  1, 0, 'h1000_0002,   0, 0, 0};
    v[11] = '{1, 'h08,   1, 0, 'h14,  0,            0,  1, 0, 1, 0, 2,  3,  1, 0, 'h1000_0002,   0, 0, 0};
    v[12] = '{1, 'h08,   1, 0, 'h14,  0,            0,  0, 1, 1, 0, 5,  4,  1, 0, 'h1000_0002,   0, 0, 0};
    v[13] = '{1, 'h08,   1, 0, 'h14,  0,            0,  1, 0, 1, 0, 2,  0,  0, 0, 0,             1, 0, 'h1000_0005};
    v[14] = '{0, 0,      0, 0, 0,     0,            0,  0, 0, 0, 0, 0,  1,  1, 0, 'h1000_0002,   0, 0, 0};
    v[15] = '{1, 'h0C,   0, 0, 0,     0,            1,  0, 0, 0, 0, 0,  0,  0, 0, 0,             0, 0, 0};
    v[16] = '{1, 'h0C,   0, 0, 0,     0,            1,  0, 0, 0, 0, 0,  0,  0, 0, 0,             0, 0, 0};
    v[17] = '{1, 'h0C,   0, 0, 0,     0,            1,  0, 0, 0, 0, 0,  0,  0, 0, 0,             0, 0, 0};
    v[18] = '{1, 'h0C,   0, 0, 0,     0,            0,  1, 0, 1, 0, 3,  0,  0, 0, 0,             0, 0, 0};
    v[19] = '{1, 'h0C,   0, 0, 0,     0,            1,  0, 0, 0, 0, 0,  0,  1, 0, 'h0020_81B3,   0, 0, 0};
    v[20] = '{1, 'h0C,   1, 0, 'h0C,  0,            1,  0, 1, 1, 0, 3,  0,  0, 0, 0,             0, 0, 0};
    v[21] = '{0, 0,      0, 0, 0,     0,            0,  0, 0, 0, 0, 0,  0,  0, 0, 0,             1, 0, 'h0020_81B3};
    v[22] = '{1, 'h3FC,  0, 0, 0,     0,            0,  1, 0, 1, 0, 255, 0, 0, 0, 0,             0, 0, 0};
    v[23] = '{0, 0,      0, 0, 0,     0,            0,  0, 0, 0, 0, 0,  0,  1, 0, 'h1000_00FF,   0, 0, 0};

    bus.f_req = 1'b1; bus.f_addr = 32'h0C;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h10; bus.l_wdata = 32'h1; bus.l_lock = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst f_gnt",    32'(bus.f_gnt),    0);
    check("rst l_gnt",    32'(bus.l_gnt),    0);
    check("rst mem_en",   32'(bus.mem_en),   0);
    check("rst mem_we",   32'(bus.mem_we),   0);
    check("rst f_rvalid", 32'(bus.f_rvalid), 0);
    check("rst l_rvalid", 32'(bus.l_rvalid), 0);
    check("rst f_err",    32'(bus.f_err),    0);
    check("rst l_err",    32'(bus.l_err),    0);
    check("rst f_rdata",  bus.f_rdata,       0);
    check("rst l_rdata",  bus.l_rdata,       0);
    check("rst starve",   32'(dut.starve_cnt), 0);

    bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.f_req   = v[i].f_req[0];
      bus.f_addr  = v[i].f_addr;
      bus.l_req   = v[i].l_req[0];
      bus.l_we    = v[i].l_we[0];
      bus.l_addr  = v[i].l_addr;
      bus.l_wdata = v[i].l_wdata;
      bus.l_lock  = v[i].l_lock[0];
      #2;
      check($sformatf("r%0d f_gnt", i),    32'(bus.f_gnt),      v[i].f_gnt);
      check($sformatf("r%0d l_gnt", i),    32'(bus.l_gnt),      v[i].l_gnt);
      check($sformatf("r%0d mem_en", i),   32'(bus.mem_en),     v[i].mem_en);
      if (v[i].mem_en[0]) begin
        check($sformatf("r%0d mem_we", i),  32'(bus.mem_we),  v[i].mem_we);
        check($sformatf("r%0d mem_idx", i), 32'(bus.mem_idx), v[i].idx);
      end
      check($sformatf("r%0d starve", i),   32'(dut.starve_cnt), v[i].starve);
      check($sformatf("r%0d f_rvalid", i), 32'(bus.f_rvalid),   v[i].f_rvalid);
      check($sformatf("r%0d f_err", i),    32'(bus.f_err),      v[i].f_err);
      check($sformatf("r%0d f_rdata", i),  bus.f_rdata,         v[i].f_rdata);
      check($sformatf("r%0d l_rvalid", i), 32'(bus.l_rvalid),   v[i].l_rvalid);
      check($sformatf("r%0d l_err", i),    32'(bus.l_err),      v[i].l_err);
      check($sformatf("r%0d l_rdata", i),  bus.l_rdata,         v[i].l_rdata);
    end

    // reset lands between a fetch grant and its response
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 32'h0C; bus.l_req = 1'b0; bus.l_lock = 1'b0;
    #2;
    check("mid f_gnt before", 32'(bus.f_gnt), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid f_gnt in rst",  32'(bus.f_gnt),  0);
    check("mid mem_en in rst", 32'(bus.mem_en), 0);
    @(posedge clk);
    #2;
    check("mid f_rvalid", 32'(bus.f_rvalid), 0);
    check("mid l_rvalid", 32'(bus.l_rvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("post starve",   32'(dut.starve_cnt), 0);
    check("post f_rvalid", 32'(bus.f_rvalid),   0);
    check("post f_gnt",    32'(bus.f_gnt),      1);
    check("post mem_idx",  32'(bus.mem_idx),    3);
    @(negedge clk);
    bus.f_req = 1'b0;
    #2;
    check("post f_rvalid2", 32'(bus.f_rvalid), 1);
    check("post f_rdata",   bus.f_rdata,       32'h0020_81B3);
    check("post f_err",     32'(bus.f_err),    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
